// File: rtl/bloom_distinct_counter.sv
// bloom_distinct_counter: streaming distinct-element counter on a k-hash Bloom filter.
// Keys flow through two stages: stage 1 registers the k filter indices, stage 2
// looks them up combinationally and commits any miss at the next edge. A clear
// request drains the pipeline, then zeroes the filter one word per cycle.
//
// state | meaning
// RUN   | accepting keys unless a clear is pending
// DRAIN | clear pending, waiting for the stage-1 key to commit
// CLEAR | zeroing filter word clr_ptr_q each cycle
module bloom_distinct_counter #(
  parameter int DATA_W      = 8,
  parameter int FILTER_BITS = 256,
  parameter int NUM_HASH    = 2,
  parameter int CNT_W       = 16,
  parameter int WORD_W      = 16
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           clear_i,
  output logic                           busy_o,
  output logic                           res_valid,
  output logic                           res_hit,
  output logic [CNT_W-1:0]               count_o,
  output logic                           count_sat_o,
  output logic [$clog2(FILTER_BITS):0]   fill_o
);

  localparam int IDX_W     = $clog2(FILTER_BITS);
  localparam int NUM_WORDS = FILTER_BITS / WORD_W;
  localparam int PTR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   clear_pend_q;
  logic [PTR_W-1:0]       clr_ptr_q;

  logic                   s1_valid_q;
  logic [IDX_W-1:0]       s1_idx_q [NUM_HASH];

  logic [FILTER_BITS-1:0] filter_q;
  logic [CNT_W-1:0]       count_q;
  logic [IDX_W:0]         fill_q;
  logic                   res_valid_q;
  logic                   res_hit_q;

  logic                   accept;
  logic                   s2_hit;
  logic                   s2_dup;
  logic [2:0]             s2_new_bits;
  logic [FILTER_BITS-1:0] s2_set_mask;

  // Multiplicative hash: top IDX_W bits of the low 32 bits of key * constant.
  function automatic logic [IDX_W-1:0] hash_idx(input logic [DATA_W-1:0] key, input int sel);
    logic [31:0] x;
    logic [31:0] c;
    logic [31:0] p;
    x = 32'(key);
    case (sel)
      0:       c = 32'h9E3779B1;
      1:       c = 32'h85EBCA77;
      2:       c = 32'hC2B2AE3D;
      default: c = 32'h27D4EB2F;
    endcase
    p = x * c;
    return IDX_W'(p >> (32 - IDX_W));
  endfunction

  assign accept      = in_valid && in_ready;
  assign busy_o      = clear_pend_q;
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign count_o     = count_q;
  assign count_sat_o = &count_q;
  assign fill_o      = fill_q;

  // Stage-2 lookup: hit when every indexed bit is set; new bits count each distinct index once.
  always_comb begin
    s2_hit      = 1'b1;
    s2_dup      = 1'b0;
    s2_new_bits = 3'd0;
    s2_set_mask = '0;
    for (int i = 0; i < NUM_HASH; i++) begin
      s2_dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (s1_idx_q[j] == s1_idx_q[i]) s2_dup = 1'b1;
      end
      if (!filter_q[s1_idx_q[i]]) begin
        s2_hit = 1'b0;
        if (!s2_dup) s2_new_bits = s2_new_bits + 3'd1;
      end
      s2_set_mask[s1_idx_q[i]] = 1'b1;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = !clear_pend_q;
        if (clear_pend_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Stage 2 is combinational over stage 1, so an empty stage 1 means nothing is left to commit.
        if (!s1_valid_q) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_ptr_q == PTR_W'(NUM_WORDS - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register, clear request latch and clear word pointer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_RUN;
      clear_pend_q <= 1'b0;
      clr_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      // Requests arriving outside RUN are ignored so a held clear_i cannot re-trigger.
      if (state_q == ST_RUN && clear_i) begin
        clear_pend_q <= 1'b1;
      end else if (state_q == ST_CLEAR && state_d == ST_RUN) begin
        clear_pend_q <= 1'b0;
      end
      if (state_q == ST_DRAIN) begin
        clr_ptr_q <= '0;
      end else if (state_q == ST_CLEAR) begin
        clr_ptr_q <= clr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Stage 1: capture the hash indices of an accepted key.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < NUM_HASH; i++) s1_idx_q[i] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        for (int i = 0; i < NUM_HASH; i++) s1_idx_q[i] <= hash_idx(in_data, i);
      end
    end
  end

  // Filter bits: set on a stage-2 miss, zeroed word by word during CLEAR.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      filter_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      filter_q[int'(clr_ptr_q) * WORD_W +: WORD_W] <= '0;
    end else if (s1_valid_q && !s2_hit) begin
      filter_q <= filter_q | s2_set_mask;
    end
  end

  // Distinct count (saturating) and fill count; both restart when CLEAR is entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_q <= '0;
      fill_q  <= '0;
    end else if (state_q == ST_DRAIN && state_d == ST_CLEAR) begin
      count_q <= '0;
      fill_q  <= '0;
    end else if (s1_valid_q && !s2_hit) begin
      if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
      fill_q <= fill_q + (IDX_W + 1)'(s2_new_bits);
    end
  end

  // Result strobe, two edges after acceptance.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
    end else begin
      res_valid_q <= s1_valid_q;
      res_hit_q   <= s1_valid_q && s2_hit;
    end
  end

endmodule

// File: tb/tb_bloom_distinct_counter.sv
// Testbench for bloom_distinct_counter: random key streams checked against a
// set-of-bits reference model, plus clear and reset scenarios. A second
// instance with a 4-bit count shares all inputs to exercise saturation.
module tb_bloom_distinct_counter;

  localparam int IDX_W = 8;
  localparam int NBITS = 256;
  localparam int NH    = 2;

  logic       wb_clk_i;
  logic       wb_rst_i;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clear_i;

  logic        in_ready, busy_o, res_valid, res_hit, count_sat_o;
  logic [15:0] count_o;
  logic [8:0]  fill_o;

  logic        sat_in_ready, sat_busy, sat_res_valid, sat_res_hit, sat_flag;
  logic [3:0]  sat_count;
  logic [8:0]  sat_fill;

  int n_checks = 0;
  int n_fail   = 0;

  bit model_bits [NBITS];
  int model_misses;
  int model_fill;
  int perm [256];

  bloom_distinct_counter u_dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear_i(clear_i), .busy_o(busy_o),
    .res_valid(res_valid), .res_hit(res_hit),
    .count_o(count_o), .count_sat_o(count_sat_o), .fill_o(fill_o)
  );

  bloom_distinct_counter #(.CNT_W(4)) u_sat (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .clear_i(clear_i), .busy_o(sat_busy),
    .res_valid(sat_res_valid), .res_hit(sat_res_hit),
    .count_o(sat_count), .count_sat_o(sat_flag), .fill_o(sat_fill)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a plain set of filter bits, hashed with 32-bit arithmetic.
  function automatic int unsigned bhash(input int unsigned key, input int i);
    int unsigned c;
    int unsigned p;
    case (i)
      0:       c = 32'h9E3779B1;
      1:       c = 32'h85EBCA77;
      2:       c = 32'hC2B2AE3D;
      default: c = 32'h27D4EB2F;
    endcase
    p = key * c;
    return p >> (32 - IDX_W);
  endfunction

  function automatic bit model_insert(input int unsigned key);
    bit hit;
    hit = 1'b1;
    for (int i = 0; i < NH; i++) if (!model_bits[bhash(key, i)]) hit = 1'b0;
    if (!hit) begin
      model_misses++;
      for (int i = 0; i < NH; i++) begin
        if (!model_bits[bhash(key, i)]) begin
          model_bits[bhash(key, i)] = 1'b1;
          model_fill++;
        end
      end
    end
    return hit;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NBITS; i++) model_bits[i] = 1'b0;
    model_misses = 0;
    model_fill   = 0;
  endfunction

  function automatic void shuffle();
    int j, tmp;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
  endfunction

  // Drive one cycle of inputs; returns whether the key was accepted at the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit clr, output bit acc);
    in_valid = v;
    in_data  = d;
    clear_i  = clr;
    acc = v && (in_ready === 1'b1);
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_reset();
    bit acc;
    wb_rst_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, acc);
    wb_rst_i = 1'b0;
    step(1'b0, 8'h00, 1'b0, acc);
    model_clear();
  endtask

  task automatic test_reset();
    bit acc;
    wb_rst_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_checks++; if (res_hit !== 1'b0) begin n_fail++; $display("FAIL reset_res_hit: got %b expected 0", res_hit); end
    n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_checks++; if (count_sat_o !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", count_sat_o); end
    n_checks++; if (fill_o !== 9'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    wb_rst_i = 1'b0;
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (sat_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_sat_in_ready: got %b expected 1", sat_in_ready); end
    model_clear();
  endtask

  task automatic test_back_to_back();
    bit acc, h0, h1;
    step(1'b1, 8'h05, 1'b0, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept0: got %b expected 1", acc); end
    h0 = model_insert(32'h05);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency1: got %b expected 0", res_valid); end
    step(1'b1, 8'h05, 1'b0, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept1: got %b expected 1", acc); end
    h1 = model_insert(32'h05);
    n_checks++; if (res_valid !== 1'b1 || res_hit !== h0) begin n_fail++; $display("FAIL b2b_first: got valid=%b hit=%b expected valid=1 hit=%b", res_valid, res_hit, h0); end
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (res_valid !== 1'b1 || res_hit !== h1) begin n_fail++; $display("FAIL b2b_second: got valid=%b hit=%b expected valid=1 hit=%b", res_valid, res_hit, h1); end
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", res_valid); end
    n_checks++; if (count_o !== 16'(model_misses)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", count_o, model_misses); end
    n_checks++; if (fill_o !== 9'(model_fill) || fill_o < 9'd1 || fill_o > 9'd2) begin n_fail++; $display("FAIL b2b_fill: got %0d expected %0d", fill_o, model_fill); end
  endtask

  task automatic test_stream_all();
    bit acc, acc_d, hit_d, hit_now, v;
    int stalls, hits;
    acc_d = 1'b0; hit_d = 1'b0; stalls = 0; hits = 0;
    shuffle();
    for (int t = 0; t < 258; t++) begin
      v = (t < 256);
      step(v, v ? 8'(perm[t]) : 8'h00, 1'b0, acc);
      if (v && !acc) stalls++;
      hit_now = acc ? model_insert(32'(perm[t])) : 1'b0;
      if (acc && hit_now) hits++;
      n_checks++;
      if (res_valid !== acc_d || (acc_d && res_hit !== hit_d)) begin
        n_fail++;
        $display("FAIL stream_res t=%0d: got valid=%b hit=%b expected valid=%b hit=%b", t, res_valid, res_hit, acc_d, hit_d);
      end
      acc_d = acc; hit_d = hit_now;
    end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    n_checks++; if (count_o !== 16'(model_misses)) begin n_fail++; $display("FAIL stream_count: got %0d expected %0d (hits %0d)", count_o, model_misses, hits); end
    n_checks++; if (fill_o !== 9'(model_fill)) begin n_fail++; $display("FAIL stream_fill: got %0d expected %0d", fill_o, model_fill); end
    n_checks++; if (count_sat_o !== 1'b0) begin n_fail++; $display("FAIL stream_sat: got %b expected 0", count_sat_o); end
  endtask

  task automatic test_saturation();
    bit acc, v;
    int exp_cnt;
    apply_reset();
    shuffle();
    for (int t = 0; t < 42; t++) begin
      v = (t < 40);
      step(v, v ? 8'(perm[t]) : 8'h00, 1'b0, acc);
      exp_cnt = (model_misses > 15) ? 15 : model_misses;
      n_checks++;
      if (sat_count !== 4'(exp_cnt) || sat_flag !== (model_misses >= 15) || sat_fill !== 9'(model_fill)) begin
        n_fail++;
        $display("FAIL sat_track t=%0d: got cnt=%0d sat=%b fill=%0d expected cnt=%0d sat=%b fill=%0d",
                 t, sat_count, sat_flag, sat_fill, exp_cnt, (model_misses >= 15), model_fill);
      end
      if (acc) void'(model_insert(32'(perm[t])));
    end
    n_checks++; if (sat_count !== 4'd15 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_final: got cnt=%0d sat=%b expected 15/1 (misses %0d)", sat_count, sat_flag, model_misses); end
    n_checks++; if (count_o !== 16'(model_misses)) begin n_fail++; $display("FAIL sat_wide_count: got %0d expected %0d", count_o, model_misses); end
  endtask

  task automatic test_clear_inflight();
    bit acc, acc_d, hit_d, got;
    int low;
    logic [7:0] k1, k2;
    apply_reset();
    k1 = 8'h05;
    k2 = 8'($urandom_range(255, 0));
    if (k2 == k1) k2 = 8'h77;
    step(1'b1, k1, 1'b0, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL clr_accept_k1: got %b expected 1", acc); end
    hit_d = model_insert(32'(k1));
    step(1'b1, k2, 1'b1, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL clr_accept_k2: got %b expected 1", acc); end
    n_checks++; if (res_valid !== 1'b1 || res_hit !== hit_d) begin n_fail++; $display("FAIL clr_inflight1: got valid=%b hit=%b expected valid=1 hit=%b", res_valid, res_hit, hit_d); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b expected 1", busy_o); end
    hit_d = model_insert(32'(k2));
    acc_d = 1'b1;
    low = 0; got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      step(1'b1, k1, (t < 3), acc);
      n_checks++;
      if (res_valid !== acc_d || (acc_d && res_hit !== hit_d)) begin
        n_fail++;
        $display("FAIL clr_res t=%0d: got valid=%b hit=%b expected valid=%b hit=%b", t, res_valid, res_hit, acc_d, hit_d);
      end
      acc_d = 1'b0;
      if (!acc) begin
        low++;
      end else begin
        got = 1'b1;
        n_checks++; if (count_o !== 16'd0 || fill_o !== 9'd0) begin n_fail++; $display("FAIL clr_counts: got count=%0d fill=%0d expected 0/0", count_o, fill_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clr_busy_end: got %b expected 0", busy_o); end
        model_clear();
        hit_d = model_insert(32'(k1));
        acc_d = 1'b1;
      end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL clr_timeout: got in_ready=%b busy=%b expected in_ready=1 within 40 cycles", in_ready, busy_o);
    end
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (res_valid !== acc_d || res_hit !== hit_d) begin n_fail++; $display("FAIL clr_repeat_key: got valid=%b hit=%b expected valid=%b hit=%b", res_valid, res_hit, acc_d, hit_d); end
    n_checks++; if (low > 18 || low < 16) begin n_fail++; $display("FAIL clr_stall_len: got %0d expected 16..18", low); end
  endtask

  task automatic test_reset_mid_clear();
    bit acc, acc_d, hit_d, hit_now, v;
    apply_reset();
    shuffle();
    for (int t = 0; t < 10; t++) begin
      v = (t < 8);
      step(v, v ? 8'(perm[t]) : 8'h00, 1'b0, acc);
      if (acc) void'(model_insert(32'(perm[t])));
    end
    step(1'b0, 8'h00, 1'b1, acc);
    repeat (9) step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (busy_o !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rmc_mid: got busy=%b in_ready=%b expected 1/0", busy_o, in_ready); end
    wb_rst_i = 1'b1;
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++;
    if (res_valid !== 1'b0 || res_hit !== 1'b0 || count_o !== 16'd0 || count_sat_o !== 1'b0 ||
        fill_o !== 9'd0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rmc_reset_vals: got rv=%b rh=%b cnt=%0d sat=%b fill=%0d busy=%b expected all 0",
               res_valid, res_hit, count_o, count_sat_o, fill_o, busy_o);
    end
    wb_rst_i = 1'b0;
    step(1'b0, 8'h00, 1'b0, acc);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmc_in_ready: got %b expected 1", in_ready); end
    model_clear();
    acc_d = 1'b0; hit_d = 1'b0;
    for (int t = 0; t < 10; t++) begin
      v = (t < 8);
      step(v, v ? 8'(perm[t]) : 8'h00, 1'b0, acc);
      hit_now = acc ? model_insert(32'(perm[t])) : 1'b0;
      n_checks++;
      if (res_valid !== acc_d || (acc_d && res_hit !== hit_d)) begin
        n_fail++;
        $display("FAIL rmc_res t=%0d: got valid=%b hit=%b expected valid=%b hit=%b", t, res_valid, res_hit, acc_d, hit_d);
      end
      acc_d = acc; hit_d = hit_now;
    end
    n_checks++; if (fill_o !== 9'(model_fill) || count_o !== 16'(model_misses)) begin n_fail++; $display("FAIL rmc_final: got fill=%0d cnt=%0d expected fill=%0d cnt=%0d", fill_o, count_o, model_fill, model_misses); end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clear_i  = 1'b0;
    model_clear();
    test_reset();
    test_back_to_back();
    test_stream_all();
    test_saturation();
    test_clear_inflight();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
